round_key_store: RTL and testbench
==================================

Name: round_key_store

Overview:
- Consumer end of the round-key write interface driven by the key-expansion block.
- Stores up to 15 128-bit round keys written as `(addr, key, w_e)` beats. The expansion block's completion pulse marks the key set valid.
- Streams the keys to the cipher round datapath over a valid/ready handshake. Order is forward (round 0..N) for encryption or reverse (round N..0) for decryption.
- Sits between key expansion and the AES round pipeline; lets one expansion serve many blocks.

Parameters:
- KEY_S, 128, width of one round key in bits.
- MAX_KEYS, 15, number of storage entries (AES-256: 14 rounds + 1).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- w_e, input, 1, write strobe from key expansion.
- w_addr, input, 4, round index of the key being written.
- w_key, input, KEY_S, round key data.
- w_done, input, 1, one-cycle pulse: expansion complete.
- rounds_total, input, 4, number of cipher rounds (10/12/14); sampled at start.
- start, input, 1, request a key stream.
- decrypt, input, 1, 1 = reverse order; sampled at start.
- rk_ready, input, 1, consumer accepts the current key.
- rk_valid, output, 1, rk_data/rk_round valid.
- rk_data, output, KEY_S, current round key.
- rk_round, output, 4, storage index of rk_data.
- rk_last, output, 1, the current key is the final one of the stream.
- keys_valid, output, 1, a complete key set is stored.
- busy, output, 1, stream in progress or pending.
- overlap_err, output, 1, sticky: a write landed while busy.

Behaviour:
- Reset (async) forces all outputs to 0, FSM to IDLE and clears pending. Array contents are not reset.
- Writes:
  - The write is performed when w_e=1 and w_addr<MAX_KEYS; higher addresses are ignored.
  - A write to address 0 clears keys_valid in the next cycle.
  - w_done sets keys_valid in the next cycle. If w_done and a w_e to address 0 occur in the same cycle, w_done wins.
- rounds_total is latched at start as L. Values 10, 12 and 14 pass unchanged; any other value is clamped to 14. The stream length is L+1 keys.
- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - start=1 and keys_valid=1 → STREAM. The first key is presented with registered-read latency: rk_valid=1 in cycle T+1 for start in cycle T.
  - start=1 and keys_valid=0 → WAIT; busy=1.
  - start=0 → stay.
- WAIT:
  - On the cycle keys_valid becomes 1 → STREAM; first key visible one cycle later.
  - start is ignored in WAIT.
- STREAM:
  - Index starts at 0 (encrypt) or L (decrypt). rk_round equals the index.
  - rk_valid, rk_data, rk_round and rk_last are held stable while rk_valid=1 and rk_ready=0.
  - On a transfer (rk_valid & rk_ready), the next key is presented in the next cycle with no bubble. Index steps +1 (encrypt) or -1 (decrypt).
  - rk_last=1 exactly when the index equals L (encrypt) or 0 (decrypt).
  - A transfer with rk_last=1 returns the FSM to IDLE; rk_valid=0 and busy=0 in the next cycle.
  - start is ignored in STREAM, including in the cycle of the last transfer.
  - A new start is accepted from the cycle after return to IDLE.
- busy=1 in WAIT and STREAM.
- Writes while busy: the write is still performed and overlap_err is set (sticky until reset). The key currently held in rk_data is unaffected; later keys read the new contents.
- Index width is 4 bits; it never wraps because termination is on rk_last.

Test Plan:
- Write addresses 0..10 with key_i = {32'(i)} replicated, pulse w_done, rounds_total=10, decrypt=0, start, rk_ready=1 → rk_valid 1 cycle after start. Rounds 0..10 appear back-to-back, rk_last only on round 10, busy drops the cycle after.
- Same keys, decrypt=1, rounds_total=14 after writing 0..14 → rk_round sequence 14..0, rk_last on round 0, data matches stored key_i.
- Stream with rk_ready toggling 1,0,0,1 → rk_data/rk_round frozen during low-ready cycles, no key skipped or duplicated; exactly 11 transfers for rounds_total=10.
- start before w_done (keys_valid=0) → busy=1, rk_valid=0 until w_done. The first key appears 2 cycles after the w_done pulse.
- Write to address 5 mid-stream → overlap_err=1 and held. Write to addr 0 clears keys_valid; a subsequent start goes to WAIT.
- Assert reset asynchronously mid-stream (not clock-aligned) → rk_valid, busy and keys_valid go 0 immediately. After release, start goes to WAIT; rounds_total=9 is treated as 14 (15 keys).

Source files
------------

// File: rtl/round_key_store.sv
// Round-key store: captures expanded keys and streams them forward or reversed to the round datapath.
// First key one cycle after start (or after keys become valid); outputs hold while rk_ready is low.
module round_key_store #(
    parameter int KEY_S    = 128,
    parameter int MAX_KEYS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_e,
    input  logic [3:0]       w_addr,
    input  logic [KEY_S-1:0] w_key,
    input  logic             w_done,
    input  logic [3:0]       rounds_total,
    input  logic             start,
    input  logic             decrypt,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [KEY_S-1:0] rk_data,
    output logic [3:0]       rk_round,
    output logic             rk_last,
    output logic             keys_valid,
    output logic             busy,
    output logic             overlap_err
);

    localparam logic [4:0] MAX_K = 5'(MAX_KEYS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             finish;

    logic [KEY_S-1:0] key_mem [MAX_KEYS];
    logic             wr_en;
    logic [3:0]       rt_clamp;
    logic [3:0]       len_q;
    logic             dec_q;
    logic [3:0]       cfg_len;
    logic             cfg_dec;
    logic [3:0]       rd_idx;
    logic             rd_last;
    logic [KEY_S-1:0] rd_data;

    assign wr_en    = w_e && ({1'b0, w_addr} < MAX_K);
    assign rt_clamp = (rounds_total == 4'd10 || rounds_total == 4'd12 || rounds_total == 4'd14)
                      ? rounds_total : 4'd14;
    assign busy     = (state != IDLE);

    // In IDLE the stream is launched straight from the live inputs; afterwards from the latched copy.
    assign cfg_len = (state == IDLE) ? rt_clamp : len_q;
    assign cfg_dec = (state == IDLE) ? decrypt : dec_q;

    assign rd_idx  = load    ? (cfg_dec ? cfg_len : 4'd0)
                   : cfg_dec ? (rk_round - 4'd1) : (rk_round + 4'd1);
    assign rd_last = cfg_dec ? (rd_idx == 4'd0) : (rd_idx == cfg_len);
    // Forward a same-cycle write so the fetched key always reflects the newest contents.
    assign rd_data = (wr_en && (w_addr == rd_idx)) ? w_key : key_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_mem[w_addr] <= w_key;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (keys_valid) begin
                        state_nxt = STREAM;
                        load      = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (keys_valid) begin
                    state_nxt = STREAM;
                    load      = 1'b1;
                end
            end
            STREAM: begin
                if (rk_valid && rk_ready) begin
                    if (rk_last) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= 4'd0;
            rk_last  <= 1'b0;
            len_q    <= 4'd0;
            dec_q    <= 1'b0;
        end else begin
            if (load || step) begin
                rk_valid <= 1'b1;
                rk_data  <= rd_data;
                rk_round <= rd_idx;
                rk_last  <= rd_last;
            end else if (finish) begin
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
            end
            if (state == IDLE && start) begin
                len_q <= rt_clamp;
                dec_q <= decrypt;
            end
        end
    end

    // Completion beats a concurrent rewrite of round 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_valid  <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            if (w_done) begin
                keys_valid <= 1'b1;
            end else if (wr_en && (w_addr == 4'd0)) begin
                keys_valid <= 1'b0;
            end
            if (wr_en && busy) begin
                overlap_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Scoreboard bench for round_key_store: stimulus queues expected keys, a monitor checks each presented key.
module tb_round_key_store;

    logic         clk = 1'b0;
    logic         reset;
    logic         w_e;
    logic [3:0]   w_addr;
    logic [127:0] w_key;
    logic         w_done;
    logic [3:0]   rounds_total;
    logic         start;
    logic         decrypt;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         keys_valid;
    logic         busy;
    logic         overlap_err;

    always #5 clk = ~clk;

    round_key_store #(.KEY_S(128), .MAX_KEYS(15)) dut (
        .clk(clk), .reset(reset), .w_e(w_e), .w_addr(w_addr), .w_key(w_key),
        .w_done(w_done), .rounds_total(rounds_total), .start(start), .decrypt(decrypt),
        .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_data(rk_data), .rk_round(rk_round),
        .rk_last(rk_last), .keys_valid(keys_valid), .busy(busy), .overlap_err(overlap_err)
    );

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] dat;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] mem_m [15];
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    int           xfer_cnt  = 0;
    int           x0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [127:0] key_of(input int i);
        logic [31:0] w;
        w = 32'(i);
        return {w, w, w, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input logic [3:0] a, input logic [127:0] k);
        w_e    = 1'b1;
        w_addr = a;
        w_key  = k;
        if (a < 4'd15) mem_m[a] = k;
        tick();
        w_e = 1'b0;
    endtask

    task automatic pulse_done();
        w_done = 1'b1;
        tick();
        w_done = 1'b0;
    endtask

    task automatic push_stream(input logic [3:0] len, input logic dec);
        exp_t       e;
        logic [3:0] idx;
        for (int k = 0; k <= int'(len); k++) begin
            idx    = dec ? (len - 4'(k)) : 4'(k);
            e.rnd  = idx;
            e.dat  = mem_m[idx];
            e.last = (idx == (dec ? 4'd0 : len));
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, 128'(busy), 128'(0));
    endtask

    // Monitor: every presented key is compared with the scoreboard head; a transfer pops it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rk_valid) begin
                check("sb_nonempty", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("rk_round", 128'(rk_round), 128'(e.rnd));
                    check("rk_data", rk_data, e.dat);
                    check("rk_last", 128'(rk_last), 128'(e.last));
                    if (rk_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0]   pat;
        logic [127:0] new_k;
        pat          = 4'b1001;
        new_k        = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        reset        = 1'b1;
        w_e          = 1'b0;
        w_addr       = 4'd0;
        w_key        = '0;
        w_done       = 1'b0;
        rounds_total = 4'd10;
        start        = 1'b0;
        decrypt      = 1'b0;
        rk_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        check("rst_rk_valid", 128'(rk_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_keys_valid", 128'(keys_valid), 128'(0));
        check("rst_overlap", 128'(overlap_err), 128'(0));
        check("rst_rk_data", rk_data, 128'(0));
        tick();

        // Encrypt, 10 rounds, continuous ready
        for (int i = 0; i <= 10; i++) write_key(4'(i), key_of(i));
        pulse_done();
        check("kv_after_done", 128'(keys_valid), 128'(1));
        push_stream(4'd10, 1'b0);
        x0    = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("enc_first_valid", 128'(rk_valid), 128'(1));
        check("enc_busy", 128'(busy), 128'(1));
        repeat (10) tick();
        check("enc_busy_at_last", 128'(busy), 128'(1));
        check("enc_last_round", 128'(rk_round), 128'(10));
        tick();
        check("enc_busy_drop", 128'(busy), 128'(0));
        check("enc_valid_drop", 128'(rk_valid), 128'(0));
        check("enc_xfers", 128'(xfer_cnt - x0), 128'(11));

        // Decrypt, 14 rounds
        for (int i = 0; i <= 14; i++) write_key(4'(i), key_of(i));
        pulse_done();
        rounds_total = 4'd14;
        decrypt      = 1'b1;
        push_stream(4'd14, 1'b1);
        x0    = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("dec_first_round", 128'(rk_round), 128'(14));
        wait_idle("dec_idle");
        check("dec_xfers", 128'(xfer_cnt - x0), 128'(15));

        // Backpressure pattern 1,0,0,1
        rounds_total = 4'd10;
        decrypt      = 1'b0;
        push_stream(4'd10, 1'b0);
        x0    = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 80 && busy; c++) begin
            rk_ready = pat[c % 4];
            tick();
        end
        rk_ready = 1'b1;
        check("bp_idle", 128'(busy), 128'(0));
        check("bp_xfers", 128'(xfer_cnt - x0), 128'(11));

        // Rewriting round 0 invalidates the set; start then waits for completion
        write_key(4'd0, key_of(0));
        check("kv_cleared", 128'(keys_valid), 128'(0));
        check("no_overlap_idle", 128'(overlap_err), 128'(0));
        push_stream(4'd10, 1'b0);
        x0    = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wait_busy", 128'(busy), 128'(1));
        repeat (3) tick();
        check("wait_no_valid", 128'(rk_valid), 128'(0));
        pulse_done();
        check("wait_valid_d1", 128'(rk_valid), 128'(0));
        tick();
        check("wait_valid_d2", 128'(rk_valid), 128'(1));
        wait_idle("wait_idle");
        check("wait_xfers", 128'(xfer_cnt - x0), 128'(11));

        // Write during a stream: flagged, and the later key carries the new value
        mem_m[5] = new_k;
        push_stream(4'd10, 1'b0);
        x0    = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        write_key(4'd5, new_k);
        check("overlap_set", 128'(overlap_err), 128'(1));
        check("overlap_kv", 128'(keys_valid), 128'(1));
        wait_idle("ovl_idle");
        check("overlap_sticky", 128'(overlap_err), 128'(1));
        check("ovl_xfers", 128'(xfer_cnt - x0), 128'(11));

        // Asynchronous reset mid-stream, then clamped length from WAIT
        rk_ready = 1'b0;
        push_stream(4'd10, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_valid", 128'(rk_valid), 128'(1));
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 128'(rk_valid), 128'(0));
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_kv", 128'(keys_valid), 128'(0));
        check("arst_overlap", 128'(overlap_err), 128'(0));
        exp_q.delete();
        #3 reset = 1'b0;
        tick();
        rk_ready     = 1'b1;
        rounds_total = 4'd9;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_wait", 128'(busy), 128'(1));
        check("post_rst_novalid", 128'(rk_valid), 128'(0));
        push_stream(4'd14, 1'b0);
        x0 = xfer_cnt;
        pulse_done();
        tick();
        check("clamp_first_valid", 128'(rk_valid), 128'(1));
        wait_idle("clamp_idle");
        check("clamp_xfers", 128'(xfer_cnt - x0), 128'(15));

        check("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
